// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the NoC local-port network interface.
//   - Direction codes carried in the flit dest field (EAST/WEST/LOCAL, 11 illegal).
//   - Flit layout: bit0 valid, [2:1] dest, [15:3] payload.
//   - Injection FSM state encoding.
//   - Helpers: flit packing and a 16-bit saturating increment.
// Optional feature macro used by noc_local_port: NOC_LOCAL_PORT_STATS_EN.
package noc_pkg;

  localparam int FLIT_W      = 16;
  localparam int DEST_W      = 2;
  localparam int PAYLOAD_W   = 13;
  localparam int VALID_BIT   = 0;
  localparam int DEST_LSB    = 1;
  localparam int PAYLOAD_LSB = 3;

  localparam logic [1:0] EAST    = 2'b00;
  localparam logic [1:0] WEST    = 2'b01;
  localparam logic [1:0] LOCAL   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_STALL = 2'd2
  } tx_state_e;

  // Build a valid flit from its destination and payload fields.
  function automatic logic [FLIT_W-1:0] make_flit(input logic [DEST_W-1:0] dest,
                                                  input logic [PAYLOAD_W-1:0] payload);
    return {payload, dest, 1'b1};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/noc_sync_queue.sv
// noc_sync_queue: single-clock circular buffer.
//   Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
//   Ports: clk, reset (async, active-high), push/din (write side),
//          pop/dout (read side, dout shows the head entry), full, empty, count.
// A push on a full queue succeeds only when a pop frees the head in the same
// cycle; a pop on an empty queue is ignored.
module noc_sync_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == {CW{1'b0}});
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy count; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/noc_local_port.sv
// noc_local_port: host network interface for the router local port.
//   Host TX side : tx_valid/tx_ready handshake, tx_dest, tx_payload, tx_err pulse.
//   Router inject: writeL, dataInL (registered); fullL, almost_fullL flow control.
//   Router eject : dataOutL (bit0 = valid), captured every valid cycle.
//   Host RX side : rx_valid/rx_ready handshake, rx_dest, rx_payload, sticky rx_overflow.
//   Optional     : NOC_LOCAL_PORT_STATS_EN adds saturating tx_count/rx_count/drop_count.
//   Clock clk, asynchronous active-high reset.
module noc_local_port
  import noc_pkg::*;
#(
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DEST_W-1:0]    tx_dest,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 tx_err,
  output logic                 writeL,
  output logic [FLIT_W-1:0]    dataInL,
  input  logic                 fullL,
  input  logic                 almost_fullL,
  input  logic [FLIT_W-1:0]    dataOutL,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DEST_W-1:0]    rx_dest,
  output logic [PAYLOAD_W-1:0] rx_payload,
`ifdef NOC_LOCAL_PORT_STATS_EN
  output logic [15:0]          tx_count,
  output logic [15:0]          rx_count,
  output logic [15:0]          drop_count,
`endif
  output logic                 rx_overflow
);

  localparam int TXCW = $clog2(TXQ_DEPTH) + 1;
  localparam int RXCW = $clog2(RXQ_DEPTH) + 1;
  localparam logic [TXCW-1:0] TXQ_FULL_CNT = TXCW'(TXQ_DEPTH);
  localparam logic [1:0] IDLE  = TX_IDLE;
  localparam logic [1:0] SEND  = TX_SEND;
  localparam logic [1:0] STALL = TX_STALL;

  // ---------------- injection path ----------------
  logic [FLIT_W-1:0] txq_head;
  logic              txq_full;
  logic              txq_empty;
  logic [TXCW-1:0]   txq_count;
  logic              tx_accept;
  logic              tx_illegal;
  logic              tx_push;
  logic              can_write;
  logic [1:0]        state;
  logic [1:0]        next_state;

  assign tx_ready   = (txq_count < TXQ_FULL_CNT);
  assign tx_accept  = tx_valid & tx_ready;
  assign tx_illegal = (tx_dest == ILLEGAL);
  assign tx_push    = tx_accept & ~tx_illegal & ~txq_full;

  // writeL is the registered copy of last cycle's decision, so a write issued
  // last cycle is already in the router pipeline when almost_fullL is seen;
  // blocking on (almost_fullL & writeL) keeps it from claiming the last slot twice.
  assign can_write = ~txq_empty & ~fullL & ~(almost_fullL & writeL);

  noc_sync_queue #(
    .DEPTH (TXQ_DEPTH),
    .WIDTH (FLIT_W)
  ) u_txq (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (make_flit(tx_dest, tx_payload)),
    .pop   (can_write),
    .dout  (txq_head),
    .full  (txq_full),
    .empty (txq_empty),
    .count (txq_count)
  );

  // Next-state decode; SEND means a write is on writeL in the following cycle.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (txq_empty) begin
          next_state = IDLE;
        end else begin
          next_state = can_write ? SEND : STALL;
        end
      end
      SEND: begin
        if (can_write) begin
          next_state = SEND;
        end else if (!txq_empty) begin
          next_state = STALL;
        end else begin
          next_state = IDLE;
        end
      end
      STALL: begin
        if (can_write) begin
          next_state = SEND;
        end else if (!txq_empty) begin
          next_state = STALL;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state, registered router outputs and the illegal-destination pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      writeL  <= 1'b0;
      dataInL <= {FLIT_W{1'b0}};
      tx_err  <= 1'b0;
    end else begin
      state  <= next_state;
      writeL <= can_write;
      tx_err <= tx_accept & tx_illegal;
      if (can_write) begin
        dataInL <= txq_head;
      end else begin
        dataInL <= dataInL;
      end
    end
  end

  // ---------------- ejection path ----------------
  logic [FLIT_W-2:0] rxq_head;
  logic              rxq_full;
  logic              rxq_empty;
  logic [RXCW-1:0]   rxq_count;
  logic              rx_capture;
  logic              rx_drop;

  assign rx_capture = dataOutL[VALID_BIT];
  assign rx_drop    = rx_capture & rxq_full & ~rx_ready;
  assign rx_valid   = (rxq_count != {RXCW{1'b0}});
  assign rx_dest    = rxq_head[DEST_LSB-1 +: DEST_W];
  assign rx_payload = rxq_head[PAYLOAD_LSB-1 +: PAYLOAD_W];

  // The valid bit is implied by occupancy, so only bits [15:1] are stored.
  noc_sync_queue #(
    .DEPTH (RXQ_DEPTH),
    .WIDTH (FLIT_W - 1)
  ) u_rxq (
    .clk   (clk),
    .reset (reset),
    .push  (rx_capture),
    .din   (dataOutL[FLIT_W-1:1]),
    .pop   (rx_ready & ~rxq_empty),
    .dout  (rxq_head),
    .full  (rxq_full),
    .empty (rxq_empty),
    .count (rxq_count)
  );

  // Sticky loss flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= rx_overflow | rx_drop;
    end
  end

`ifdef NOC_LOCAL_PORT_STATS_EN
  // Saturating event counters for router writes, captures and drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count   <= 16'd0;
      rx_count   <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      tx_count   <= can_write ? sat_inc(tx_count) : tx_count;
      rx_count   <= (rx_capture & ~rx_drop) ? sat_inc(rx_count) : rx_count;
      drop_count <= rx_drop ? sat_inc(drop_count) : drop_count;
    end
  end
`endif

endmodule

// File: tb/tb_noc_local_port.sv
module tb_noc_local_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [1:0]  tx_dest = 2'b00;
  logic [12:0] tx_payload = 13'd0;
  logic        tx_err;
  logic        writeL;
  logic [15:0] dataInL;
  logic        fullL = 1'b0;
  logic        almost_fullL = 1'b0;
  logic [15:0] dataOutL = 16'd0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [1:0]  rx_dest;
  logic [12:0] rx_payload;
  logic        rx_overflow;
`ifdef NOC_LOCAL_PORT_STATS_EN
  logic [15:0] tx_count, rx_count, drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] tx_exp[$];
  logic [15:0] rx_exp[$];

  noc_local_port #(.TXQ_DEPTH(4), .RXQ_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_dest      (tx_dest),
    .tx_payload   (tx_payload),
    .tx_err       (tx_err),
    .writeL       (writeL),
    .dataInL      (dataInL),
    .fullL        (fullL),
    .almost_fullL (almost_fullL),
    .dataOutL     (dataOutL),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_dest      (rx_dest),
    .rx_payload   (rx_payload),
`ifdef NOC_LOCAL_PORT_STATS_EN
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .drop_count   (drop_count),
`endif
    .rx_overflow  (rx_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] flit(input logic [1:0] d, input logic [12:0] p);
    return {p, d, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the edge; any write is scored.
  task automatic step();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (writeL === 1'b1) begin
      checks++;
      assert (tx_exp.size() != 0) else begin
        errors++;
        $error("FAIL tx_unexpected_write observed=%0h expected=none", dataInL);
      end
      if (tx_exp.size() != 0) begin
        e = tx_exp.pop_front();
        checks++;
        assert (dataInL === e) else begin
          errors++;
          $error("FAIL tx_flit observed=%0h expected=%0h", dataInL, e);
        end
      end
    end
  endtask

  task automatic rx_head_chk(input string tag);
    logic [15:0] e;
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    e = rx_exp.pop_front();
    chk({tag, "_flit"}, 32'({rx_payload, rx_dest}), 32'(e[15:1]));
  endtask

  initial begin
    // ---- reset values ----
    #12;
    chk("rst_writeL", 32'(writeL), 32'd0);
    chk("rst_dataInL", 32'(dataInL), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_dest", 32'(rx_dest), 32'd0);
    chk("rst_rx_payload", 32'(rx_payload), 32'd0);
    chk("rst_rx_overflow", 32'(rx_overflow), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    step();

    // ---- idle after reset: 5 back-to-back messages to West ----
    for (int k = 0; k < 9; k++) begin
      if (k < 5) begin
        tx_valid = 1'b1; tx_dest = 2'b01; tx_payload = 13'h0AA + 13'(k);
        tx_exp.push_back(flit(2'b01, 13'h0AA + 13'(k)));
      end else begin
        tx_valid = 1'b0;
      end
      step();
      chk("idle_writeL", 32'(writeL), 32'(k >= 1 && k <= 5));
    end

    // ---- backpressure with fullL held ----
    fullL = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_valid = 1'b1; tx_dest = 2'b00; tx_payload = 13'h100 + 13'(k);
      tx_exp.push_back(flit(2'b00, 13'h100 + 13'(k)));
      step();
      tx_valid = 1'b0;
      chk("bp_writeL", 32'(writeL), 32'd0);
    end
    chk("bp_tx_ready", 32'(tx_ready), 32'd0);
    step();
    chk("bp_hold_writeL", 32'(writeL), 32'd0);
    fullL = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("bp_drain_writeL", 32'(writeL), 32'(k < 4));
    end
    chk("bp_tx_ready_back", 32'(tx_ready), 32'd1);

    // ---- almost_full throttling ----
    fullL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1'b1; tx_dest = 2'b10; tx_payload = 13'h150 + 13'(k);
      tx_exp.push_back(flit(2'b10, 13'h150 + 13'(k)));
      step();
    end
    tx_valid = 1'b0;
    almost_fullL = 1'b1;
    fullL = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("af_writeL", 32'(writeL), 32'((k % 2 == 0) && k <= 4));
    end
    almost_fullL = 1'b0;

    // ---- illegal destination ----
    tx_valid = 1'b1; tx_dest = 2'b11; tx_payload = 13'h1FFF;
    step();
    tx_valid = 1'b0;
    chk("ill_tx_err", 32'(tx_err), 32'd1);
    chk("ill_writeL", 32'(writeL), 32'd0);
    step();
    chk("ill_tx_err_clear", 32'(tx_err), 32'd0);
    chk("ill_writeL2", 32'(writeL), 32'd0);
    fullL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1'b1; tx_dest = 2'b01; tx_payload = 13'h0C0 + 13'(k);
      tx_exp.push_back(flit(2'b01, 13'h0C0 + 13'(k)));
      step();
    end
    tx_valid = 1'b0;
    chk("ill_count_unchanged", 32'(tx_ready), 32'd1);
    fullL = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("tx_scoreboard_empty", 32'(tx_exp.size()), 32'd0);

    // ---- pop and capture together on a full ejection queue ----
    for (int k = 0; k < 5; k++) begin
      dataOutL = flit(2'(k), 13'h0D0 + 13'(k));
      rx_exp.push_back(dataOutL);
      if (k == 4) begin
        rx_head_chk("rxfull_pop");
        rx_ready = 1'b1;
      end
      step();
      rx_ready = 1'b0;
      if (k == 0) chk("rx_latency_valid", 32'(rx_valid), 32'd1);
    end
    dataOutL = 16'd0;
    chk("rxfull_no_overflow", 32'(rx_overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rx_head_chk("rxfull_drain");
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
    chk("rxfull_empty", 32'(rx_valid), 32'd0);

    // ---- ejection overflow ----
    for (int k = 0; k < 5; k++) begin
      dataOutL = flit(2'b10, 13'h200 + 13'(k));
      if (k < 4) rx_exp.push_back(dataOutL);
      step();
      if (k == 3) chk("ovf_before", 32'(rx_overflow), 32'd0);
    end
    dataOutL = 16'd0;
    chk("ovf_set", 32'(rx_overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      rx_head_chk("ovf_drain");
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
    chk("ovf_drained", 32'(rx_valid), 32'd0);
    chk("ovf_sticky", 32'(rx_overflow), 32'd1);
    chk("rx_scoreboard_empty", 32'(rx_exp.size()), 32'd0);

    // ---- mid-operation reset ----
    fullL = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_valid = 1'b1; tx_dest = 2'b00; tx_payload = 13'h300 + 13'(k);
      tx_exp.push_back(flit(2'b00, 13'h300 + 13'(k)));
      step();
    end
    tx_valid = 1'b0;
    dataOutL = flit(2'b10, 13'h0EE);
    step();
    dataOutL = 16'd0;
    fullL = 1'b0;
    step();
    chk("mid_writeL_high", 32'(writeL), 32'd1);
    chk("mid_rx_valid_high", 32'(rx_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_writeL", 32'(writeL), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_overflow", 32'(rx_overflow), 32'd0);
    tx_exp.delete();
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_writeL", 32'(writeL), 32'd0);
    end
    chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
